// File: rtl/wb_commit_pkg.sv
// Shared constants and types for the write-back commit slice.
// Imported by the GPR bank and the wb_commit top.
package wb_commit_pkg;

  localparam logic RST_ENABLE = 1'b1;

  localparam int GPR_W       = 32;
  localparam int GPR_AW      = 5;
  localparam int TRACE_WEN_W = 4;

  localparam logic [31:0] ZEROWORD32 = 32'h0;
  localparam logic [4:0]  ZEROWORD5  = 5'h0;

  typedef logic [GPR_W-1:0]  gpr_bus_t;
  typedef logic [GPR_AW-1:0] gpr_addr_bus_t;

endpackage

// File: rtl/wb_gpr_bank.sv
// GPR array with hard-wired $0 and two write-first read ports.
// Same-cycle WB writes are forwarded to both read ports.
module wb_gpr_bank
  import wb_commit_pkg::*;
#(
  parameter int DATA_W = GPR_W,
  parameter int ADDR_W = GPR_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rt_data
);

  localparam int N = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [N];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < N; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (we && waddr == rs_addr) begin
      rs_data = wdata;
    end else begin
      rs_data = regs[rs_addr];
    end
  end

  always_comb begin
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (we && waddr == rt_addr) begin
      rt_data = wdata;
    end else begin
      rt_data = regs[rt_addr];
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Write-back stage: GPR bank, HI/LO, retire counter and debug trace.
// A held bundle (wb_new=0) rewrites state but never commits twice.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int DATA_W = GPR_W,
  parameter int ADDR_W = GPR_AW,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_new,
  input  logic                   wb_regfile_write_enable,
  input  logic [ADDR_W-1:0]      wb_regfile_write_addr,
  input  logic [DATA_W-1:0]      wb_regfile_write_data,
  input  logic                   wb_hi_write_enable,
  input  logic [DATA_W-1:0]      wb_hi_write_data,
  input  logic                   wb_lo_write_enable,
  input  logic [DATA_W-1:0]      wb_lo_write_data,
  input  logic [31:0]            wb_pc,
  input  logic [ADDR_W-1:0]      rs_addr,
  output logic [DATA_W-1:0]      rs_data,
  input  logic [ADDR_W-1:0]      rt_addr,
  output logic [DATA_W-1:0]      rt_data,
  output logic [DATA_W-1:0]      hi_data,
  output logic [DATA_W-1:0]      lo_data,
  output logic [31:0]            debug_wb_pc,
  output logic [TRACE_WEN_W-1:0] debug_wb_rf_wen,
  output logic [ADDR_W-1:0]      debug_wb_rf_wnum,
  output logic [DATA_W-1:0]      debug_wb_rf_wdata,
  output logic [CNT_W-1:0]       retired_count
);

  logic              commit;
  logic              trace_wen;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  wb_gpr_bank #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_gpr (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_regfile_write_enable),
    .waddr  (wb_regfile_write_addr),
    .wdata  (wb_regfile_write_data),
    .rs_addr(rs_addr),
    .rs_data(rs_data),
    .rt_addr(rt_addr),
    .rt_data(rt_data)
  );

  // pc==0 marks a bubble or flushed slot
  assign commit = wb_new && (wb_pc != ZEROWORD32);

  assign trace_wen = commit
                  && wb_regfile_write_enable
                  && (wb_regfile_write_addr != '0);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hi_q          <= '0;
      lo_q          <= '0;
      retired_count <= '0;
    end else begin
      if (wb_hi_write_enable) hi_q <= wb_hi_write_data;
      if (wb_lo_write_enable) lo_q <= wb_lo_write_data;
      if (commit) retired_count <= retired_count + 1'b1;
    end
  end

  always_comb begin
    hi_data = wb_hi_write_enable ? wb_hi_write_data : hi_q;
    lo_data = wb_lo_write_enable ? wb_lo_write_data : lo_q;
  end

  always_comb begin
    debug_wb_pc       = commit ? wb_pc : ZEROWORD32;
    debug_wb_rf_wen   = {TRACE_WEN_W{trace_wen}};
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (trace_wen) begin
      debug_wb_rf_wnum  = wb_regfile_write_addr;
      debug_wb_rf_wdata = wb_regfile_write_data;
    end
  end

endmodule
